// File: rtl/alu_result_demux_if.sv
// Handshake bundle between the ALU stage, the block, and its two consumers.
// slave = block view, master = producer/consumer (bench) view.
interface alu_result_demux_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [RD_W-1:0]   in_rd;
  logic              in_select;
  logic              out0_valid;
  logic              out0_ready;
  logic [DATA_W-1:0] out0_data;
  logic [RD_W-1:0]   out0_rd;
  logic              out1_valid;
  logic              out1_ready;
  logic [DATA_W-1:0] out1_data;
  logic [CNT_W-1:0]  drop_count;

  modport slave (
    input  in_valid, in_data, in_rd, in_select, out0_ready, out1_ready,
    output in_ready, out0_valid, out0_data, out0_rd, out1_valid, out1_data, drop_count
  );

  modport master (
    output in_valid, in_data, in_rd, in_select, out0_ready, out1_ready,
    input  in_ready, out0_valid, out0_data, out0_rd, out1_valid, out1_data, drop_count
  );
endinterface

// File: rtl/alu_result_demux.sv
// Routes ALU results in order to writeback (ch0) or memory (ch1) through a 2-entry FIFO;
// 1-cycle latency, in_ready depends only on occupancy (no path from out*_ready); x0 writes dropped.
module alu_result_demux #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input logic               clk,
  input logic               rst,
  alu_result_demux_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] data_q [2];
  logic [RD_W-1:0]   rd_q   [2];
  logic              sel_q  [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic in_ready;
  logic accept;
  logic drop;
  logic push;
  logic pop;
  logic head_sel;

  always_comb begin
    in_ready = (count_q != 2'd2) && !rst;
    accept   = bus.in_valid && in_ready;
    drop     = accept && !bus.in_select && (bus.in_rd == '0);
    push     = accept && !drop;
    head_sel = sel_q[rd_ptr_q];
    // Only the channel the head is routed to may pop it.
    pop      = (count_q != 2'd0) && (head_sel ? bus.out1_ready : bus.out0_ready);

    wr_ptr_d = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? ~rd_ptr_q : rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    drop_d   = (drop && (drop_q != '1)) ? drop_q + CNT_ONE : drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        sel_q[i]  <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      drop_q   <= '0;
    end else begin
      if (push) begin
        data_q[wr_ptr_q] <= bus.in_data;
        rd_q[wr_ptr_q]   <= bus.in_rd;
        sel_q[wr_ptr_q]  <= bus.in_select;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out0_valid = (count_q != 2'd0) && !head_sel;
  assign bus.out1_valid = (count_q != 2'd0) && head_sel;
  assign bus.out0_data  = data_q[rd_ptr_q];
  assign bus.out1_data  = data_q[rd_ptr_q];
  assign bus.out0_rd    = rd_q[rd_ptr_q];
  assign bus.drop_count = drop_q;
endmodule

// File: doc/alu_result_demux.md
# alu_result_demux

Routes each ALU result to one of two consumers: register-file writeback (channel 0) or the store/memory unit (channel 1). It is the output-side counterpart of the ALU operand mux. A 2-entry in-order FIFO decouples the ALU stage from downstream stalls using valid/ready handshakes. Writes to x0 are discarded, and the block keeps a saturating count of discarded writes.

## Interface
Parameters:
- DATA_W, 32, width of the ALU result
- RD_W, 5, width of the destination register index
- CNT_W, 16, width of the drop counter

Ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  ALU result valid
- in_ready  output  1  block can accept a result this cycle
- in_data  input  DATA_W  ALU result
- in_rd  input  RD_W  destination register index (channel 0 only)
- in_select  input  1  0 = route to channel 0 (writeback), 1 = route to channel 1 (memory)
- out0_valid  output  1  writeback entry valid
- out0_ready  input  1  register file accepts the entry
- out0_data  output  DATA_W  writeback data
- out0_rd  output  RD_W  writeback register index
- out1_valid  output  1  memory entry valid
- out1_ready  input  1  memory unit accepts the entry
- out1_data  output  DATA_W  memory address/data
- drop_count  output  CNT_W  number of discarded x0 writes, saturating

## Operation
- **Storage:** 2-entry FIFO. Each entry holds {data, rd, select}. Internal pointers are 1 bit each, plus a 2-bit occupancy count (0..2).
- **Accept:** an input is accepted when in_valid && in_ready.
  - in_ready = (count != 2) && !rst. It depends only on state and rst; there is no combinational path from out*_ready.
- **Drop rule:** an accepted input with in_select == 0 and in_rd == 0 is not enqueued.
  - drop_count increments by 1 and saturates at all-ones.
  - Drops do not affect FIFO state.
- **Presentation:** the head entry drives both data buses, so out0_data == out1_data == head data and out0_rd == head rd.
  - out0_valid = (count != 0) && (head.select == 0).
  - out1_valid = (count != 0) && (head.select == 1).
  - The two valids are never high together.
- **Pop:** the head is popped when the active channel sees valid && ready. The ready of the inactive channel is ignored.
- **Ordering:** strictly in-order across both channels. A stalled head blocks later entries, even those destined for the other channel.
- **Simultaneous push and pop:** allowed when count is 1. Count stays at 1 and the new entry becomes the head next cycle.
  - At count 2, push is impossible because in_ready = 0.
  - At count 0, only a push can occur.
- **Valid stability:** once out*_valid is high, the head's data, rd and channel stay constant until popped or reset.
- **Reset:** takes effect at the clock edge and overrides any in-flight handshake. Any in-flight transfer in that cycle is lost.
  - count = 0, pointers = 0, all FIFO entries = 0, drop_count = 0.
  - Therefore out0_valid = out1_valid = 0, and out0_data, out1_data and out0_rd read 0.
  - in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.

## Timing
- **Latency:** an input accepted at edge N appears on out*_valid in the cycle after edge N (1 cycle) when the FIFO was empty.
- **Throughput:**
  - 1 entry per cycle when the consumer holds ready high.
  - After a full stall, in_ready rises in the cycle after the first pop.
- **drop_count:** updates at the same edge as the dropping accept.
- **Outputs:** all outputs are registered or decoded from registered state, except in_ready's rst term.

## Test plan
- **Reset:** assert rst for 2 cycles with in_valid = 1.
  - Required: in_ready = 0, out0_valid = out1_valid = 0, drop_count = 0. Nothing is enqueued.
  - After release: in_ready = 1.
- **Single route:** push {data 0xDEADBEEF, rd 5, sel 0} with out0_ready = 1.
  - Required: out0_valid = 1 one cycle later with out0_data = 0xDEADBEEF and out0_rd = 5. Popped that cycle; out1_valid stays 0.
- **Full/backpressure:** hold out1_ready = 0, then push sel 1 with data 1, 2, 3.
  - Required: the first two are accepted and in_ready = 0 once count = 2.
  - Then raise out1_ready for 1 cycle: 1 is popped, in_ready returns to 1 the next cycle, and 3 is accepted.
  - Output order must be 1, 2, 3.
- **Cross-channel ordering:** push A (sel 1), then B (sel 0), with out1_ready = 0 and out0_ready = 1.
  - Required: B is not presented (out0_valid = 0) until A pops. B appears the cycle after A's handshake.
- **x0 drop:** push {sel 0, rd 0} three times, then {sel 1, rd 0, data 0x10}.
  - Required: drop_count = 3, with no channel-0 output.
  - Required: channel 1 delivers 0x10, since rd is ignored for sel 1.
  - Force drop_count to all-ones via 2^CNT_W drops: it stays at 0xFFFF.
- **Mid-operation reset:** with 2 entries queued and out0_ready = 1, assert rst for 1 cycle.
  - Required: no entry is delivered after the reset edge, both valids are 0, and count is empty.
  - Required: the next push after release appears with 1-cycle latency.
